rs_enc_punct: RTL and testbench

Parametrised systematic Reed-Solomon encoder over GF(2^8), the successor to the fixed RS(255,239,8) encoder. It supports per-block shortening (runtime K) and parity puncturing (runtime T ≤ T_MAX) as required by the OFDM burst profiles. It sits between the randomizer byte stream and the convolutional encoder. Data moves on valid/ready byte streams in both directions.

---
 rtl/rs_pkg.sv | 44 ++++
 rtl/rs_gf_mul_const.sv | 15 +
 rtl/rs_enc_punct.sv | 158 +++++++++++++++
 tb/tb_rs_enc_punct.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - GF(2^8) constants, RS generator builder and encoder state type
package rs_pkg;

  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam int RS_N = 255;
  localparam int RS_K = 239;
  localparam int RS_T = 8;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  // Room for up to 32 parity taps plus the monic top coefficient.
  typedef logic [32:0][7:0] gen_max_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ GF_POLY) : (x << 1);
    end
    return p;
  endfunction

  // g(x) = prod_{i=0}^{np-1} (x + alpha^i), coefficient i at byte i.
  function automatic gen_max_t gen_poly(input int np);
    gen_max_t g;
    logic [7:0] root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < np; i++) begin
      for (int j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g;
  endfunction

  localparam gen_max_t GEN_ALL = gen_poly(2 * RS_T);
  localparam logic [2*RS_T-1:0][7:0] GEN = GEN_ALL[2*RS_T-1:0];

endpackage

// File: rtl/rs_gf_mul_const.sv
// rtl/rs_gf_mul_const.sv - combinational GF(2^8) multiply by an elaboration-time constant
module rs_gf_mul_const
  import rs_pkg::*;
#(
  parameter logic [7:0] C = 8'h01
) (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = gf_mul(a_i, C);
  end

endmodule

// File: rtl/rs_enc_punct.sv
// rtl/rs_enc_punct.sv - systematic RS(255,239) encoder with runtime shortening and parity puncturing
module rs_enc_punct
  import rs_pkg::*;
#(
  parameter int T_MAX = 8,
  parameter int K_MAX = 239
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cfg_k,
  input  logic [3:0] cfg_t,
  output logic       cfg_err,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam int NP = 2 * T_MAX;
  localparam gen_max_t G = gen_poly(NP);
  localparam logic [7:0] K_MAX_B = K_MAX[7:0];
  localparam logic [3:0] T_MAX_B = 4'(T_MAX);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [3:0] t_q;
  logic [7:0] b_q [NP];
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic       out_last_q;
  logic       busy_q;

  logic [7:0] fb;
  logic [7:0] prod [NP];
  logic [7:0] feed_d [NP];
  logic [7:0] shift_d [NP];
  logic       cfg_bad;
  logic       can_load;
  logic       in_acc;

  // The first byte of a codeword sees a cleared LFSR without spending a cycle on it.
  assign fb = in_data ^ ((state_q == IDLE) ? 8'h00 : b_q[NP-1]);

  for (genvar gi = 0; gi < NP; gi++) begin : g_tap
    rs_gf_mul_const #(.C(G[gi])) u_mul (
      .a_i(fb),
      .y_o(prod[gi])
    );
  end

  always_comb begin
    feed_d[0]  = prod[0];
    shift_d[0] = 8'h00;
    for (int i = 1; i < NP; i++) begin
      feed_d[i]  = prod[i] ^ ((state_q == IDLE) ? 8'h00 : b_q[i-1]);
      shift_d[i] = b_q[i-1];
    end
  end

  always_comb begin
    cfg_bad  = (cfg_k == 8'd0) || (cfg_k > K_MAX_B) || (cfg_t > T_MAX_B);
    cfg_err  = (state_q == IDLE) && cfg_bad;
    can_load = !out_valid_q || out_ready;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = reset_n && !cfg_bad && can_load;
      DATA:    in_ready = can_load;
      default: in_ready = 1'b0;
    endcase
    in_acc = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NP; i++) b_q[i] <= '0;
    end else begin
      if (out_valid_q && out_ready && out_last_q) busy_q <= 1'b0;
      if (can_load) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (in_acc) begin
            busy_q      <= 1'b1;
            t_q         <= cfg_t;
            b_q         <= feed_d;
            out_valid_q <= 1'b1;
            out_data_q  <= in_data;
            if (cfg_k == 8'd1) begin
              if (cfg_t == 4'd0) begin
                out_last_q <= 1'b1;
                cnt_q      <= '0;
              end else begin
                state_q <= PARITY;
                cnt_q   <= {3'b000, cfg_t, 1'b0} - 8'd1;
              end
            end else begin
              state_q <= DATA;
              cnt_q   <= cfg_k - 8'd1;
            end
          end
        end
        DATA: begin
          // cnt_q counts data bytes still to come, this one included.
          if (in_acc) begin
            b_q         <= feed_d;
            out_valid_q <= 1'b1;
            out_data_q  <= in_data;
            if (cnt_q == 8'd1) begin
              if (t_q == 4'd0) begin
                state_q    <= IDLE;
                out_last_q <= 1'b1;
                cnt_q      <= '0;
              end else begin
                state_q <= PARITY;
                cnt_q   <= {3'b000, t_q, 1'b0} - 8'd1;
              end
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        PARITY: begin
          if (can_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= b_q[NP-1];
            b_q         <= shift_d;
            if (cnt_q == 8'd0) begin
              state_q    <= IDLE;
              out_last_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rs_enc_punct.sv
// tb/tb_rs_enc_punct.sv - randomized self-checking bench against a polynomial-division RS model
module tb_rs_enc_punct;
  import rs_pkg::*;

  localparam int TM = 8;
  localparam int KM = 239;
  localparam int NPAR = 2 * TM;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] cfg_k;
  logic [3:0] cfg_t;
  logic       cfg_err;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  rs_enc_punct #(.T_MAX(TM), .K_MAX(KM)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_k    (cfg_k),
    .cfg_t    (cfg_t),
    .cfg_err  (cfg_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int gexp [0:509];
  int glog [0:255];
  int gpol [0:NPAR];

  function automatic int mul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[glog[a] + glog[b]];
  endfunction

  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 510; i++) begin
      gexp[i] = x;
      if (i < 255) glog[x] = i;
      x = x << 1;
      if (x > 255) x = x ^ 'h11D;
    end
    for (int i = 0; i <= NPAR; i++) gpol[i] = 0;
    gpol[0] = 1;
    for (int r = 0; r < NPAR; r++) begin
      int nxt [0:NPAR];
      for (int i = 0; i <= NPAR; i++) nxt[i] = mul(gpol[i], gexp[r]);
      for (int i = 1; i <= NPAR; i++) nxt[i] = nxt[i] ^ gpol[i-1];
      for (int i = 0; i <= NPAR; i++) gpol[i] = nxt[i];
    end
  endtask

  logic [7:0] msg [0:KM-1];
  logic [8:0] exp_q [$];
  int         stamps [$];
  int         cyc = 0;
  bit         rdy_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Long division of the zero-padded full-length message by g(x).
  task automatic model_cw(input int k, input int t);
    int r [0:KM+NPAR-1];
    int pad;
    pad = KM - k;
    for (int i = 0; i < KM + NPAR; i++) r[i] = 0;
    for (int i = 0; i < k; i++) r[pad+i] = int'(msg[i]);
    for (int i = 0; i < KM; i++) begin
      int c;
      c = r[i];
      if (c != 0)
        for (int j = 0; j <= NPAR; j++) r[i+j] = r[i+j] ^ mul(c, gpol[NPAR-j]);
    end
    for (int i = 0; i < k; i++) exp_q.push_back({(i == k - 1) && (t == 0), msg[i]});
    for (int p = 0; p < 2 * t; p++) exp_q.push_back({p == 2 * t - 1, 8'(r[KM+p])});
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e[7:0]);
        check("out_last", out_last, e[8]);
      end
      stamps.push_back(cyc);
    end
  end

  task automatic drive_cw(input int k, input int t);
    model_cw(k, t);
    cfg_k = 8'(k);
    cfg_t = 4'(t);
    for (int i = 0; i < k; i++) begin
      bit acc;
      int wd;
      in_valid = 1'b1;
      in_data  = msg[i];
      acc = 0;
      wd  = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        wd++;
        if (!acc && wd > 2000) begin
          check("in_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
      if (i == 0) begin
        cfg_k = 8'($urandom);
        cfg_t = 4'($urandom);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int wd;
    wd = 0;
    while (exp_q.size() != 0 && wd < 20000) begin
      @(posedge clk);
      wd++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    #1;
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);
  endtask

  int         ks [8];
  int         ts [8];
  logic [7:0] store [8][0:59];
  int         total;

  initial begin
    build_tables();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cfg_k    = 8'd10;
    cfg_t    = 4'd4;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_cfg_err", cfg_err, 0);
    reset_n = 1'b1;

    for (int i = 0; i < NPAR; i++) check("gen_coef", GEN[i], gpol[i]);

    @(posedge clk); #1;
    cfg_k = 8'd0; cfg_t = 4'd4; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    check("err_k0", cfg_err, 1);
    check("err_k0_rdy", in_ready, 0);
    @(posedge clk); #1;
    cfg_k = 8'd240;
    @(negedge clk);
    check("err_k240", cfg_err, 1);
    check("err_k240_rdy", in_ready, 0);
    @(posedge clk); #1;
    cfg_k = 8'd10; cfg_t = 4'd9;
    @(negedge clk);
    check("err_t9", cfg_err, 1);
    check("err_t9_rdy", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("err_no_out", out_valid, 0);
    check("err_no_busy", busy, 0);
    cfg_t = 4'd4;
    @(negedge clk);
    check("ok_cfg_err", cfg_err, 0);
    check("ok_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < KM; i++) msg[i] = 8'h00;
    drive_cw(KM, TM);
    wait_drain();

    msg[0] = 8'h01;
    drive_cw(1, TM);
    wait_drain();

    for (int i = 0; i < 36; i++) msg[i] = 8'($urandom);
    drive_cw(36, 4);
    wait_drain();

    stamps.delete();
    for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
    drive_cw(10, 0);
    for (int i = 0; i < 7; i++) msg[i] = 8'($urandom);
    drive_cw(7, 2);
    wait_drain();
    check("bypass_count", stamps.size(), 21);
    if (stamps.size() > 0) check("bypass_no_gap", stamps[stamps.size()-1] - stamps[0], 20);

    total = 0;
    for (int c = 0; c < 8; c++) begin
      ks[c] = $urandom_range(1, 60);
      ts[c] = $urandom_range(0, TM);
      total += ks[c] + 2 * ts[c];
      for (int i = 0; i < 60; i++) store[c][i] = 8'($urandom);
    end
    rdy_rand = 1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < ks[c]; i++) msg[i] = store[c][i];
      drive_cw(ks[c], ts[c]);
    end
    wait_drain();
    rdy_rand = 0;
    @(posedge clk); #1;
    stamps.delete();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < ks[c]; i++) msg[i] = store[c][i];
      drive_cw(ks[c], ts[c]);
    end
    wait_drain();
    check("b2b_count", stamps.size(), total);
    if (stamps.size() > 0) check("b2b_rate", stamps[stamps.size()-1] - stamps[0], total - 1);

    for (int i = 0; i < 4; i++) msg[i] = 8'($urandom);
    drive_cw(4, TM);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_last", out_last, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) msg[i] = 8'($urandom);
    drive_cw(12, TM);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
